// File: rtl/sar_pkg.sv
// Shared types and sizing helpers for the successive-approximation search controller.
package sar_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } sar_state_t;

   localparam int unsigned SAR_DEF_WIDTH = 8;
   localparam int unsigned SAR_DEF_IDX_W = $clog2(SAR_DEF_WIDTH);

   // Bit-index register width for a given operand width; never below one bit.
   function automatic int unsigned sar_idx_w(input int unsigned width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage : sar_pkg

// File: rtl/sar_search.sv
// Successive-approximation search: drives trial values on probe and reads back
// gte/eq from an external comparator, resolving one result bit per clock.
module sar_search
   import sar_pkg::*;
#(
   parameter int unsigned WIDTH = SAR_DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] probe,
   input  logic             gte,
   input  logic             eq,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned IDX_W = sar_idx_w(WIDTH);
   localparam logic [IDX_W-1:0] K_TOP = IDX_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

   sar_state_t       state;
   logic [IDX_W-1:0] k;
   logic [WIDTH-1:0] acc;

   logic [WIDTH-1:0] bit_k_c;
   logic [WIDTH-1:0] acc_upd_c;
   logic [WIDTH-1:0] next_probe_c;

   // Trial mask decoded from k, accumulator with the current bit resolved, and the following trial.
   always_comb begin
      bit_k_c      = WIDTH'(1) << k;
      acc_upd_c    = gte ? (acc | bit_k_c) : (acc & ~bit_k_c);
      next_probe_c = acc_upd_c | (bit_k_c >> 1);
   end

   // Search FSM with registered probe/busy/done/result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         k      <= K_TOP;
         acc    <= '0;
         probe  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               probe <= '0;
               busy  <= 1'b0;
               if (start) begin
                  state <= SEARCH;
                  acc   <= '0;
                  k     <= K_TOP;
                  probe <= MSB_MASK;
                  busy  <= 1'b1;
               end
            end
            SEARCH: begin
               if (eq) begin
                  // Exact hit: the current trial is the target.
                  result <= probe;
                  state  <= DONE;
                  probe  <= '0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
               end else if (k == '0) begin
                  acc    <= acc_upd_c;
                  result <= acc_upd_c;
                  state  <= DONE;
                  probe  <= '0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
               end else begin
                  acc   <= acc_upd_c;
                  k     <= k - IDX_W'(1);
                  probe <= next_probe_c;
               end
            end
            DONE: begin
               state <= IDLE;
               acc   <= '0;
               k     <= K_TOP;
               probe <= '0;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               acc   <= '0;
               k     <= K_TOP;
               probe <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule : sar_search

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: behavioural comparators, result scoreboards,
// probe-sequence and handshake checks on an 8-bit and a 4-bit instance.
module tb_sar_search;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start8, start4;
   logic [7:0] target8, probe8, result8;
   logic [3:0] target4, probe4, result4;
   logic       gte8, eq8, busy8, done8;
   logic       gte4, eq4, busy4, done4;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [7:0] res8_q[$];
   logic [3:0] res4_q[$];

   // Behavioural comparators on the target/probe pair.
   assign gte8 = (target8 >= probe8);
   assign eq8  = (target8 == probe8);
   assign gte4 = (target4 >= probe4);
   assign eq4  = (target4 == probe4);

   sar_search #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .probe(probe8),
      .gte(gte8), .eq(eq8), .busy(busy8), .done(done8), .result(result8)
   );

   sar_search #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .probe(probe4),
      .gte(gte4), .eq(eq4), .busy(busy4), .done(done4), .result(result4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // One 8-bit search: checks every trial value, the latency, the result and the done pulse.
   task automatic search8(input logic [7:0] t);
      logic [31:0] exp_p[$];
      logic [31:0] ep;
      logic [7:0]  a, p;
      logic [7:0]  er;
      int          exp_n, cyc;
      bit          seen;
      a = 8'd0;
      for (int b = 7; b >= 0; b--) begin
         p = a | (8'd1 << b);
         exp_p.push_back(32'(p));
         if (p == t) break;
         if (t >= p) a = p;
      end
      exp_n = exp_p.size();
      @(negedge clk);
      target8 = t;
      start8  = 1'b1;
      res8_q.push_back(t);
      @(negedge clk);
      start8 = 1'b0;
      cyc  = 0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done8) begin
            seen = 1'b1;
            break;
         end
         ep = (exp_p.size() > 0) ? exp_p.pop_front() : 32'hFFFF_FFFF;
         check("busy8_search", 32'(busy8), 32'd1);
         check("probe8_seq", 32'(probe8), ep);
         cyc++;
         @(negedge clk);
      end
      check("done8_seen", 32'(seen), 32'd1);
      if (seen) begin
         er = (res8_q.size() > 0) ? res8_q.pop_front() : 8'hxx;
         check("result8", 32'(result8), 32'(er));
         check("cmp_count8", 32'(cyc), 32'(exp_n));
         check("busy8_in_done", 32'(busy8), 32'd0);
         check("probe8_in_done", 32'(probe8), 32'd0);
         @(negedge clk);
         check("done8_single", 32'(done8), 32'd0);
         check("result8_held", 32'(result8), 32'(t));
      end
   endtask

   // One 4-bit search for the sweep.
   task automatic search4(input logic [3:0] t);
      logic [3:0] er;
      int  cyc;
      bit  seen;
      @(negedge clk);
      target4 = t;
      start4  = 1'b1;
      res4_q.push_back(t);
      @(negedge clk);
      start4 = 1'b0;
      cyc  = 0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (done4) begin
            seen = 1'b1;
            break;
         end
         cyc++;
         @(negedge clk);
      end
      check("done4_seen", 32'(seen), 32'd1);
      if (seen) begin
         er = (res4_q.size() > 0) ? res4_q.pop_front() : 4'hx;
         check("result4", 32'(result4), 32'(er));
         check("cmp_count4_le4", 32'(cyc <= 4 && cyc >= 1), 32'd1);
         @(negedge clk);
         check("done4_single", 32'(done4), 32'd0);
      end
   endtask

   initial begin
      int  dones, busy_run, last_done, cyc;
      logic [7:0] er;
      rst_n   = 1'b0;
      start8  = 1'b0;
      start4  = 1'b0;
      target8 = 8'd0;
      target4 = 4'd0;
      repeat (2) @(negedge clk);
      check("rst_probe8", 32'(probe8), 32'd0);
      check("rst_busy8", 32'(busy8), 32'd0);
      check("rst_done8", 32'(done8), 32'd0);
      check("rst_result8", 32'(result8), 32'd0);
      check("rst_probe4", 32'(probe4), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_probe8", 32'(probe8), 32'd0);

      // Full search, target 37: probes 128,64,32,48,40,36,38,37.
      search8(8'd37);

      // Reset at the 4th SEARCH cycle (probe 48) clears everything immediately.
      @(negedge clk);
      target8 = 8'd37;
      start8  = 1'b1;
      res8_q.push_back(8'd37);
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_probe8", 32'(probe8), 32'd48);
      check("pre_rst_busy8", 32'(busy8), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_probe8", 32'(probe8), 32'd0);
      check("mid_rst_busy8", 32'(busy8), 32'd0);
      check("mid_rst_done8", 32'(done8), 32'd0);
      check("mid_rst_result8", 32'(result8), 32'd0);
      res8_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      search8(8'd37);

      // Early exit on the first probe, then the boundaries.
      search8(8'd128);
      search8(8'd0);
      search8(8'd255);
      search8(8'd1);

      // start held high: back-to-back searches for 200, no restart mid-search.
      @(negedge clk);
      target8 = 8'd200;
      start8  = 1'b1;
      for (int n = 0; n < 3; n++) res8_q.push_back(8'd200);
      dones     = 0;
      busy_run  = 0;
      last_done = -1;
      cyc       = 0;
      for (int i = 0; i < 60 && dones < 3; i++) begin
         @(negedge clk);
         cyc++;
         if (busy8 && done8) check("busy_done_overlap", 32'd1, 32'd0);
         if (busy8) busy_run++;
         if (done8) begin
            er = (res8_q.size() > 0) ? res8_q.pop_front() : 8'hxx;
            check("held_result8", 32'(result8), 32'(er));
            check("held_busy_cycles", 32'(busy_run), 32'd5);
            if (last_done >= 0) check("held_period_le9", 32'((cyc - last_done) <= 9), 32'd1);
            last_done = cyc;
            busy_run  = 0;
            dones++;
         end
      end
      check("held_done_count", 32'(dones), 32'd3);
      start8 = 1'b0;
      repeat (12) @(negedge clk);
      check("held_idle_busy8", 32'(busy8), 32'd0);

      // Exhaustive sweep on the 4-bit instance.
      for (int t = 0; t < 16; t++) search4(4'(t));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_sar_search
